// File: rtl/shared_adder43_scheduler.sv
// Round-robin scheduler that time-shares one external combinational adder
// among NUM_REQ requesters. Operands and result are registered; the adder
// inputs are driven only from the operand registers.
// Optional feature: define SHARED_ADDER_PERF_EN to add perf_ops/perf_stall counters.
module shared_adder43_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned A_W     = 43,
  parameter int unsigned B_W     = 7,
  parameter int unsigned ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [A_W-1:0]         add_a,
  output logic [B_W-1:0]         add_b,
  input  logic [A_W:0]           add_sum,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [A_W:0]           rsp_sum,
`ifdef SHARED_ADDER_PERF_EN
  output logic [31:0]            perf_ops,
  output logic [31:0]            perf_stall,
`endif
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StCompute, StHold} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [A_W-1:0]  op_a_q, op_a_d;
  logic [B_W-1:0]  op_b_q, op_b_d;
  logic [ID_W-1:0] op_id_q, op_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [A_W:0]    rsp_sum_q, rsp_sum_d;

  logic            arb_en;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic            grant;
  logic [ID_W-1:0] cand;

  // Find the first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Arbitrate in IDLE, or in HOLD once the pending response retires.
  // Gated by rst so req_ready stays low while reset is held.
  always_comb begin
    arb_en    = !rst && ((state_q == StIdle) || ((state_q == StHold) && rsp_ready));
    grant     = arb_en && grant_vld;
    req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // Next-state logic for the FSM, operand and response registers.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;

    unique case (state_q)
      StIdle: begin
        if (grant) state_d = StCompute;
      end
      StCompute: begin
        rsp_sum_d   = add_sum;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = grant ? StCompute : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (grant) begin
      op_a_d   = req_a[32'(grant_idx) * A_W +: A_W];
      op_b_d   = req_b[32'(grant_idx) * B_W +: B_W];
      op_id_d  = grant_idx;
      rr_ptr_d = ID_W'((32'(grant_idx) + 1) % NUM_REQ);
    end
  end

  // State registers; reset drops any in-flight or held operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

`ifdef SHARED_ADDER_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    perf_ops_d   = perf_ops_q + 32'(grant);
    perf_stall_d = perf_stall_q + 32'((state_q == StHold) && !rsp_ready);
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

  assign add_a     = op_a_q;
  assign add_b     = op_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = (state_q != StIdle);

endmodule
